stdp_update_sched: RTL and testbench

Event detector and scheduler for STDP weight updates across NUM_PRE presynaptic synapses feeding one postsynaptic neuron. It keeps per-synapse spike-age timers and detects LTP and LTD pairing events inside a timing window. Pending updates are shared onto a single downstream weight-update unit through a valid/ready handshake, with round-robin arbitration. It sits between the spike sources and the weight-update datapath.

---
 rtl/stdp_pkg.sv | 30 +++
 rtl/stdp_spike_timer.sv | 36 +++
 rtl/stdp_update_sched.sv | 180 ++++++++++++++++++
 tb/tb_stdp_update_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared constants, types and helpers for the STDP update scheduler.
package stdp_pkg;

  localparam int unsigned NUM_PRE = 5;
  localparam int unsigned TIMER_W = 8;
  localparam int unsigned WINDOW  = 16;
  localparam int unsigned IDX_W   = $clog2(NUM_PRE);

  typedef enum logic {
    LTD = 1'b0,
    LTP = 1'b1
  } stdp_dir_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    stdp_dir_t          dir;
    logic [TIMER_W-1:0] dt;
  } upd_req_t;

  // Cyclic successor of a synapse index, wrapping at the last synapse.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_PRE - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/stdp_spike_timer.sv
// Saturating spike-age counter: reads 1 the cycle after a spike, then counts
// up to all-ones, which means "no recent spike".
module stdp_spike_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         spike_i,
  output logic [W-1:0] timer_o
);

  logic [W-1:0] timer_q;
  logic [W-1:0] timer_d;

  // Restart on spike, otherwise count up and stick at all-ones.
  always_comb begin
    timer_d = timer_q;
    if (spike_i) begin
      timer_d = W'(1);
    end else if (!(&timer_q)) begin
      timer_d = timer_q + W'(1);
    end
  end

  // Age register; reset leaves it saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '1;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer_o = timer_q;

endmodule

// File: rtl/stdp_update_sched.sv
// STDP pairing detector and round-robin scheduler feeding one weight-update
// unit over a valid/ready handshake.
module stdp_update_sched
  import stdp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_PRE-1:0] pre_spike,
  input  logic               post_spike,
  input  logic               upd_ready,
  input  logic               ovf_clr,
  output logic               upd_valid,
  output logic [IDX_W-1:0]   upd_idx,
  output logic               upd_dir,
  output logic [TIMER_W-1:0] upd_dt,
  output logic [NUM_PRE-1:0] pending,
  output logic               ovf_flag
);

  localparam logic [TIMER_W-1:0] WIN = TIMER_W'(WINDOW);

  logic [TIMER_W-1:0] pre_timer [NUM_PRE];
  logic [TIMER_W-1:0] post_timer;
  logic [TIMER_W-1:0] pre_age   [NUM_PRE];
  logic [NUM_PRE-1:0] ltp_ev;
  logic [NUM_PRE-1:0] ltd_ev;

  logic [NUM_PRE-1:0] pend_q, pend_d;
  logic [NUM_PRE-1:0] dir_q, dir_d;
  logic [TIMER_W-1:0] dt_q [NUM_PRE];
  logic [TIMER_W-1:0] dt_d [NUM_PRE];
  logic               ovf_q, ovf_d;

  sched_state_t       state_q, state_d;
  upd_req_t           req_q, req_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_PRE-1:0] grant_mask;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;

  for (genvar g = 0; g < NUM_PRE; g++) begin : g_pre_timer
    stdp_spike_timer #(.W(TIMER_W)) u_pre_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .spike_i (pre_spike[g]),
      .timer_o (pre_timer[g])
    );
  end

  stdp_spike_timer #(.W(TIMER_W)) u_post_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .spike_i (post_spike),
    .timer_o (post_timer)
  );

  // Pairing detection; a coincident pre/post spike is LTP with dt=0 only.
  always_comb begin
    ltp_ev = '0;
    ltd_ev = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      pre_age[i] = pre_spike[i] ? '0 : pre_timer[i];
      ltp_ev[i]  = post_spike && (pre_age[i] < WIN);
      ltd_ev[i]  = pre_spike[i] && !post_spike && (post_timer < WIN);
    end
  end

  // Round-robin pick: first pending synapse at or after rr_ptr, cyclically.
  always_comb begin
    int unsigned j;
    j           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_PRE; k++) begin
      j = (32'(rr_ptr_q) + 32'(k)) % NUM_PRE;
      if (!grant_found && pend_q[IDX_W'(j)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scheduler next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_found) state_d = ISSUE;
      ISSUE:   if (upd_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scheduler outputs: latch the granted request, drop it on acceptance.
  always_comb begin
    req_d      = req_q;
    valid_d    = valid_q;
    rr_ptr_d   = rr_ptr_q;
    grant_mask = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_d.idx             = grant_idx;
          req_d.dir             = dir_q[grant_idx] ? LTP : LTD;
          req_d.dt              = dt_q[grant_idx];
          valid_d               = 1'b1;
          grant_mask[grant_idx] = 1'b1;
        end
      end
      ISSUE: begin
        if (upd_ready) begin
          valid_d  = 1'b0;
          rr_ptr_d = next_idx(req_q.idx);
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  // Pending table: grant clears, new events set and overwrite dir/dt.
  always_comb begin
    pend_d = pend_q & ~grant_mask;
    dir_d  = dir_q;
    dt_d   = dt_q;
    ovf_d  = ovf_clr ? 1'b0 : ovf_q;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (ltp_ev[i] || ltd_ev[i]) begin
        if (pend_q[i] && !grant_mask[i]) begin
          ovf_d = 1'b1;
        end
        pend_d[i] = 1'b1;
        dir_d[i]  = ltp_ev[i];
        dt_d[i]   = ltp_ev[i] ? pre_age[i] : post_timer;
      end
    end
  end

  // Datapath registers for the pending table and held request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      dir_q    <= '0;
      ovf_q    <= 1'b0;
      req_q    <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_PRE; i++) begin
        dt_q[i] <= '0;
      end
    end else begin
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      ovf_q    <= ovf_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_PRE; i++) begin
        dt_q[i] <= dt_d[i];
      end
    end
  end

  assign upd_valid = valid_q;
  assign upd_idx   = req_q.idx;
  assign upd_dir   = req_q.dir;
  assign upd_dt    = req_q.dt;
  assign pending   = pend_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_stdp_update_sched.sv
// Directed scoreboard bench for stdp_update_sched.
module tb_stdp_update_sched;

  logic       clk;
  logic       rst_n;
  logic [4:0] pre_spike;
  logic       post_spike;
  logic       upd_ready;
  logic       ovf_clr;
  logic       upd_valid;
  logic [2:0] upd_idx;
  logic       upd_dir;
  logic [7:0] upd_dt;
  logic [4:0] pending;
  logic       ovf_flag;

  typedef struct {
    int idx;
    int dir;
    int dt;
    int cyc;   // expected first valid cycle, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   in_req = 0;
  int   last_acc = -10;

  stdp_update_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .upd_ready  (upd_ready),
    .ovf_clr    (ovf_clr),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_dir    (upd_dir),
    .upd_dt     (upd_dt),
    .pending    (pending),
    .ovf_flag   (ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare the presented request with the scoreboard head every
  // valid cycle, pop on acceptance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_req = 1'b0;
    end else if (upd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q[0];
        chk("req_idx", int'(upd_idx), e.idx);
        chk("req_dir", int'(upd_dir), e.dir);
        chk("req_dt", int'(upd_dt), e.dt);
        if (!in_req) begin
          in_req = 1'b1;
          chk("idle_gap", int'(cyc == last_acc + 1), 0);
          if (e.cyc >= 0) chk("req_latency", cyc, e.cyc);
        end
        if (upd_ready) begin
          void'(exp_q.pop_front());
          in_req   = 1'b0;
          last_acc = cyc;
        end
      end
    end
  end

  // Advance to just after the edge that starts cycle n.
  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spike(input int n, input logic [4:0] pre, input logic post);
    at(n);
    pre_spike  = pre;
    post_spike = post;
    at(n + 1);
    pre_spike  = '0;
    post_spike = 1'b0;
  endtask

  task automatic push(input int idx, input int dir, input int dt, input int c);
    exp_t e;
    e.idx = idx; e.dir = dir; e.dt = dt; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !upd_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", int'(done), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    rst_n      = 1'b0;
    pre_spike  = '0;
    post_spike = 1'b0;
    upd_ready  = 1'b1;
    ovf_clr    = 1'b0;

    // 1: outputs quiet in reset; post spike right after release is ignored
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(upd_valid), 0);
    chk("rst_idx", int'(upd_idx), 0);
    chk("rst_dir", int'(upd_dir), 0);
    chk("rst_dt", int'(upd_dt), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_ovf", int'(ovf_flag), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b = cyc;
    spike(b, 5'b00000, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("t1_pending", int'(pending), 0);
      chk("t1_valid", int'(upd_valid), 0);
    end

    // 2: LTP pre[2]@10, post@15 -> idx2 dir1 dt5, valid at 17 only
    b = cyc + 40;
    push(2, 1, 5, b + 17);
    spike(b + 10, 5'b00100, 1'b0);
    spike(b + 15, 5'b00000, 1'b1);
    at(b + 18);
    @(negedge clk);
    chk("t2_valid_drop", int'(upd_valid), 0);
    wait_drain();

    // 3: LTD dt3; separation 16 gives nothing; separation 15 gives dt15
    b = cyc + 40;
    push(0, 0, 3, b + 15);
    spike(b + 10, 5'b00000, 1'b1);
    spike(b + 13, 5'b00001, 1'b0);
    spike(b + 40, 5'b00010, 1'b0);
    spike(b + 56, 5'b00000, 1'b1);
    at(b + 58);
    @(negedge clk);
    chk("t3_window16_pending", int'(pending), 0);
    push(0, 1, 15, b + 97);
    spike(b + 80, 5'b00001, 1'b0);
    spike(b + 95, 5'b00000, 1'b1);
    wait_drain();

    // 4: two synapses captured together, ready stalled for 5 cycles
    b = cyc + 40;
    push(1, 1, 2, b + 24);
    push(3, 1, 2, b + 31);
    spike(b + 20, 5'b01010, 1'b0);
    upd_ready = 1'b0;
    spike(b + 22, 5'b00000, 1'b1);
    at(b + 23);
    @(negedge clk);
    chk("t4_pending_both", int'(pending), 5'b01010);
    at(b + 29);
    upd_ready = 1'b1;
    at(b + 30);
    @(negedge clk);
    chk("t4_gap_valid", int'(upd_valid), 0);
    wait_drain();

    // 5: coincident pre/post is LTP dt0; re-arm during issue; overflow
    b = cyc + 40;
    upd_ready = 1'b0;
    at(b + 5);
    @(negedge clk);
    chk("t5_ovf_initial", int'(ovf_flag), 0);
    push(4, 1, 0, b + 12);
    push(4, 0, 5, -1);
    spike(b + 6, 5'b00000, 1'b1);
    spike(b + 10, 5'b10000, 1'b1);
    spike(b + 13, 5'b10000, 1'b0);
    at(b + 14);
    @(negedge clk);
    chk("t5_rearm_pending", int'(pending), 5'b10000);
    chk("t5_rearm_no_ovf", int'(ovf_flag), 0);
    spike(b + 15, 5'b10000, 1'b0);
    at(b + 16);
    @(negedge clk);
    chk("t5_ovf_set", int'(ovf_flag), 1);
    at(b + 18);
    ovf_clr = 1'b1;
    at(b + 19);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("t5_ovf_clr", int'(ovf_flag), 0);
    at(b + 20);
    upd_ready = 1'b1;
    wait_drain();

    // 6: asynchronous reset in the middle of an issue
    b = cyc + 40;
    upd_ready = 1'b0;
    push(2, 1, 3, b + 5);
    spike(b, 5'b00100, 1'b0);
    spike(b + 3, 5'b00000, 1'b1);
    at(b + 6);
    @(negedge clk);
    chk("t6_valid_before", int'(upd_valid), 1);
    at(b + 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(upd_valid), 0);
    chk("t6_async_pending", int'(pending), 0);
    exp_q.delete();
    at(b + 9);
    rst_n     = 1'b1;
    upd_ready = 1'b1;
    spike(b + 10, 5'b00000, 1'b1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k % 10 == 2) begin
        chk("t6_post_rst_valid", int'(upd_valid), 0);
        chk("t6_post_rst_pending", int'(pending), 0);
      end
    end
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
